// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller for the MEM stage.
// Arbitrates a single-ported, variable-latency memory between the pipeline
// port (P) and a debug/loader port (D), builds byte enables and replicated
// store data, lane-shifts load data and flags misaligned or timed-out accesses.
module dmem_access_ctrl #(
  parameter int MAX_P_GRANTS = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_req,
  input  logic        p_we,
  input  logic [31:0] p_addr,
  input  logic [31:0] p_wdata,
  input  logic [2:0]  p_dm_ctrl,
  output logic        p_stall,
  output logic [31:0] p_rdata,
  output logic [1:0]  p_bias,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_dm_ctrl,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  localparam int GW = $clog2(MAX_P_GRANTS + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [GW-1:0] G_MAX  = GW'(MAX_P_GRANTS);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Access size classes; undefined encodings fall back to word.
  function automatic logic is_half(input logic [2:0] c);
    return (c == 3'b001) || (c == 3'b010);
  endfunction

  function automatic logic is_byte(input logic [2:0] c);
    return (c == 3'b011) || (c == 3'b100);
  endfunction

  function automatic logic misaligned(input logic [2:0] c, input logic [1:0] a);
    if (is_byte(c))      return 1'b0;
    else if (is_half(c)) return a[0];
    else                 return (a != 2'b00);
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] c, input logic [1:0] a);
    if (is_byte(c))      return 4'b0001 << a;
    else if (is_half(c)) return 4'b0011 << {a[1], 1'b0};
    else                 return 4'b1111;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] c, input logic [31:0] wd);
    if (is_byte(c))      return {4{wd[7:0]}};
    else if (is_half(c)) return {2{wd[15:0]}};
    else                 return wd;
  endfunction

  state_t      state_q, state_d;
  logic        owner_q, owner_d;          // 1 = debug port owns the access
  logic [1:0]  lane_q, lane_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] p_rdata_q, p_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic [1:0]  p_bias_q, p_bias_d;
  logic        err_q, err_d;
  logic        d_done_q, d_done_d;

  logic        sel_d_s;
  logic        sel_we_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic [2:0]  sel_ctrl_s;
  logic [31:0] shifted_s;

  // Arbitration choice and the request fields of the winning port.
  always_comb begin
    sel_d_s     = d_req && (!p_req || (gcnt_q == G_MAX));
    sel_we_s    = sel_d_s ? d_we      : p_we;
    sel_addr_s  = sel_d_s ? d_addr    : p_addr;
    sel_wdata_s = sel_d_s ? d_wdata   : p_wdata;
    sel_ctrl_s  = sel_d_s ? d_dm_ctrl : p_dm_ctrl;
    shifted_s   = mem_rdata >> {lane_q, 3'b000};
  end

  // Next-state and registered-output logic of the access FSM.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lane_d      = lane_q;
    gcnt_d      = gcnt_q;
    tcnt_d      = tcnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    p_rdata_d   = p_rdata_q;
    d_rdata_d   = d_rdata_q;
    p_bias_d    = p_bias_q;
    err_d       = 1'b0;
    d_done_d    = 1'b0;

    // The fairness counter only tracks P wins while D is actually waiting.
    if (!d_req) begin
      gcnt_d = '0;
    end else begin
      gcnt_d = gcnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (sel_d_s || p_req) begin
          owner_d = sel_d_s;
          lane_d  = sel_addr_s[1:0];
          if (sel_d_s) begin
            gcnt_d = '0;
          end else if (d_req) begin
            gcnt_d = gcnt_q + GW'(1);
          end else begin
            gcnt_d = '0;
          end
          if (misaligned(sel_ctrl_s, sel_addr_s[1:0])) begin
            // Skip the memory entirely; stores are dropped.
            state_d  = ST_DONE;
            err_d    = 1'b1;
            d_done_d = sel_d_s;
            if (sel_d_s) begin
              d_rdata_d = 32'h0000_0000;
            end else begin
              p_rdata_d = 32'h0000_0000;
              p_bias_d  = sel_addr_s[1:0];
            end
          end else begin
            state_d     = ST_BUSY;
            tcnt_d      = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = sel_we_s;
            mem_addr_d  = {sel_addr_s[31:2], 2'b00};
            mem_be_d    = byte_en(sel_ctrl_s, sel_addr_s[1:0]);
            mem_wdata_d = store_data(sel_ctrl_s, sel_wdata_s);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          d_done_d  = owner_q;
          if (owner_q) begin
            d_rdata_d = shifted_s;
          end else begin
            p_rdata_d = shifted_s;
            p_bias_d  = lane_q;
          end
        end else if (tcnt_q == T_LAST) begin
          // Memory never answered: abandon the access and flag it.
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = 1'b1;
          d_done_d  = owner_q;
          if (owner_q) begin
            d_rdata_d = 32'h0000_0000;
          end else begin
            p_rdata_d = 32'h0000_0000;
            p_bias_d  = lane_q;
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      lane_q      <= 2'b00;
      gcnt_q      <= '0;
      tcnt_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0000_0000;
      p_rdata_q   <= 32'h0000_0000;
      d_rdata_q   <= 32'h0000_0000;
      p_bias_q    <= 2'b00;
      err_q       <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lane_q      <= lane_d;
      gcnt_q      <= gcnt_d;
      tcnt_q      <= tcnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      p_rdata_q   <= p_rdata_d;
      d_rdata_q   <= d_rdata_d;
      p_bias_q    <= p_bias_d;
      err_q       <= err_d;
      d_done_q    <= d_done_d;
    end
  end

  // Stall drops combinationally in the DONE cycle of a P access.
  assign p_stall   = p_req && !((state_q == ST_DONE) && !owner_q);
  assign p_rdata   = p_rdata_q;
  assign p_bias    = p_bias_q;
  assign d_done    = d_done_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed testbench for dmem_access_ctrl with a small latency-programmable
// memory responder and hand-computed expected values.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_req, p_we, d_req, d_we;
  logic [31:0] p_addr, p_wdata, d_addr, d_wdata;
  logic [2:0]  p_dm_ctrl, d_dm_ctrl;
  logic        p_stall, d_done, mem_req, mem_we, mem_ack, err;
  logic [31:0] p_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  p_bias;
  logic [3:0]  mem_be;

  int          n_vec  = 0;
  int          n_miss = 0;

  int          ack_lat = 1;   // 0 = memory never acks
  int          ack_cnt = 0;
  logic [31:0] rd_val  = 32'h0;

  dmem_access_ctrl #(.MAX_P_GRANTS(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_dm_ctrl(p_dm_ctrl), .p_stall(p_stall), .p_rdata(p_rdata), .p_bias(p_bias),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_dm_ctrl(d_dm_ctrl), .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  // Memory responder: ack ack_lat cycles after mem_req rises, for one cycle.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        ack_cnt   = 0;
      end else if (!mem_req) begin
        ack_cnt = 0;
      end else if (ack_lat != 0) begin
        ack_cnt = ack_cnt + 1;
        if (ack_cnt == ack_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = rd_val;
        end
      end
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One P access, started on a falling edge; returns what was seen on the bus.
  task automatic p_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] c, output int stall_n, output int err_n,
                          output int req_n, output logic [3:0] be, output logic [31:0] ma,
                          output logic [31:0] mwd, output logic mwe);
    stall_n = 0; err_n = 0; req_n = 0; be = 4'h0; ma = 32'h0; mwd = 32'h0; mwe = 1'b0;
    p_we = we; p_addr = a; p_wdata = wd; p_dm_ctrl = c; p_req = 1'b1;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (mem_req) begin
        req_n = req_n + 1;
        be = mem_be; ma = mem_addr; mwd = mem_wdata; mwe = mem_we;
      end
      if (err) err_n = err_n + 1;
      if (!p_stall) break;
      stall_n = stall_n + 1;
      @(negedge clk);
    end
    p_req = 1'b0;
    @(negedge clk);
  endtask

  int          s_n, e_n, r_n;
  logic [3:0]  be_o;
  logic [31:0] ma_o, mwd_o;
  logic        mwe_o;
  int          grants, dones;
  logic        prev_req;
  logic [31:0] grant_addr [10];
  logic [31:0] exp_addr;

  initial begin
    rst = 1'b0;
    p_req = 1'b0; p_we = 1'b0; p_addr = 32'h0; p_wdata = 32'h0; p_dm_ctrl = 3'b000;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_dm_ctrl = 3'b000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_vec("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check_vec("rst_mem_be", {28'h0, mem_be}, 32'h0);
    check_vec("rst_err", {31'h0, err}, 32'h0);
    check_vec("rst_d_done", {31'h0, d_done}, 32'h0);
    check_vec("rst_p_rdata", p_rdata, 32'h0);
    check_vec("rst_mem_addr", mem_addr, 32'h0);
    @(negedge clk);

    // Aligned word load, ack on the third BUSY cycle.
    ack_lat = 3; rd_val = 32'hDEADBEEF;
    p_access(1'b0, 32'h100, 32'h0, 3'b000, s_n, e_n, r_n, be_o, ma_o, mwd_o, mwe_o);
    check_vec("wload_stall", 32'(s_n), 32'd4);
    check_vec("wload_be", {28'h0, be_o}, 32'hF);
    check_vec("wload_addr", ma_o, 32'h100);
    check_vec("wload_err", 32'(e_n), 32'd0);
    check_vec("wload_rdata", p_rdata, 32'hDEADBEEF);
    check_vec("wload_bias", {30'h0, p_bias}, 32'h0);

    // Byte store at 0x103, minimum latency.
    ack_lat = 1; rd_val = 32'h0;
    p_access(1'b1, 32'h103, 32'h000000A5, 3'b011, s_n, e_n, r_n, be_o, ma_o, mwd_o, mwe_o);
    check_vec("bstore_addr", ma_o, 32'h100);
    check_vec("bstore_be", {28'h0, be_o}, 32'h8);
    check_vec("bstore_wdata", mwd_o, 32'hA5A5A5A5);
    check_vec("bstore_we", {31'h0, mwe_o}, 32'h1);
    check_vec("bstore_stall", 32'(s_n), 32'd2);

    // Byte load back from 0x103: lane 3 shifted down.
    rd_val = 32'hA5000000;
    p_access(1'b0, 32'h103, 32'h0, 3'b100, s_n, e_n, r_n, be_o, ma_o, mwd_o, mwe_o);
    check_vec("bload_rdata", p_rdata, 32'h000000A5);
    check_vec("bload_bias", {30'h0, p_bias}, 32'h3);
    check_vec("bload_be", {28'h0, be_o}, 32'h8);

    // Halfword store at 0x102 replicates the low half.
    p_access(1'b1, 32'h102, 32'hFFFF1234, 3'b001, s_n, e_n, r_n, be_o, ma_o, mwd_o, mwe_o);
    check_vec("hstore_be", {28'h0, be_o}, 32'hC);
    check_vec("hstore_wdata", mwd_o, 32'h12341234);

    // Unsigned halfword load at 0x102.
    rd_val = 32'hBEEF0000;
    p_access(1'b0, 32'h102, 32'h0, 3'b010, s_n, e_n, r_n, be_o, ma_o, mwd_o, mwe_o);
    check_vec("hload_rdata", p_rdata, 32'h0000BEEF);
    check_vec("hload_bias", {30'h0, p_bias}, 32'h2);

    // Misaligned halfword load: no memory traffic, one err pulse.
    p_access(1'b0, 32'h101, 32'h0, 3'b001, s_n, e_n, r_n, be_o, ma_o, mwd_o, mwe_o);
    check_vec("mis_req", 32'(r_n), 32'd0);
    check_vec("mis_err", 32'(e_n), 32'd1);
    check_vec("mis_rdata", p_rdata, 32'h0);
    check_vec("mis_stall", 32'(s_n), 32'd1);
    check_vec("mis_bias", {30'h0, p_bias}, 32'h1);

    // P and D both held: four P grants, then one D.
    ack_lat = 1; rd_val = 32'hCAFEF00D;
    p_addr = 32'h200; p_we = 1'b0; p_dm_ctrl = 3'b000;
    d_addr = 32'h300; d_we = 1'b0; d_dm_ctrl = 3'b000;
    p_req = 1'b1; d_req = 1'b1;
    grants = 0; dones = 0; prev_req = 1'b0;
    for (int i = 0; i < 100 && grants < 10; i++) begin
      #1;
      if (d_done) dones = dones + 1;
      if (mem_req && !prev_req) begin
        grant_addr[grants] = mem_addr;
        grants = grants + 1;
      end
      prev_req = mem_req;
      if (grants < 10) @(negedge clk);
    end
    p_req = 1'b0; d_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (d_done) dones = dones + 1;
    end
    check_vec("arb_grants", 32'(grants), 32'd10);
    for (int i = 0; i < 10; i++) begin
      exp_addr = (i == 4 || i == 9) ? 32'h300 : 32'h200;
      check_vec($sformatf("arb_grant%0d", i), grant_addr[i], exp_addr);
    end
    check_vec("arb_d_done", 32'(dones), 32'd2);
    check_vec("arb_d_rdata", d_rdata, 32'hCAFEF00D);
    @(negedge clk);

    // Memory never acks: abort after 8 BUSY cycles.
    ack_lat = 0;
    p_access(1'b0, 32'h400, 32'h0, 3'b000, s_n, e_n, r_n, be_o, ma_o, mwd_o, mwe_o);
    check_vec("to_req_cycles", 32'(r_n), 32'd8);
    check_vec("to_err", 32'(e_n), 32'd1);
    check_vec("to_rdata", p_rdata, 32'h0);
    check_vec("to_stall", 32'(s_n), 32'd9);
    #1;
    check_vec("to_idle_req", {31'h0, mem_req}, 32'h0);

    // Normal access after the timeout.
    ack_lat = 1; rd_val = 32'h11223344;
    p_access(1'b0, 32'h404, 32'h0, 3'b000, s_n, e_n, r_n, be_o, ma_o, mwd_o, mwe_o);
    check_vec("post_to_rdata", p_rdata, 32'h11223344);
    check_vec("post_to_err", 32'(e_n), 32'd0);
    check_vec("post_to_stall", 32'(s_n), 32'd2);

    // Asynchronous reset in the middle of a BUSY access.
    ack_lat = 0;
    p_addr = 32'h500; p_we = 1'b0; p_dm_ctrl = 3'b000; p_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_vec("busy_req", {31'h0, mem_req}, 32'h1);
    #1;
    rst = 1'b0;
    #1;
    check_vec("arst_mem_req", {31'h0, mem_req}, 32'h0);
    check_vec("arst_p_rdata", p_rdata, 32'h0);
    check_vec("arst_err", {31'h0, err}, 32'h0);
    @(negedge clk);
    rst = 1'b1; p_req = 1'b0;
    @(negedge clk);
    ack_lat = 1; rd_val = 32'h55AA55AA;
    p_access(1'b0, 32'h600, 32'h0, 3'b000, s_n, e_n, r_n, be_o, ma_o, mwd_o, mwe_o);
    check_vec("post_rst_rdata", p_rdata, 32'h55AA55AA);
    check_vec("post_rst_stall", 32'(s_n), 32'd2);
    check_vec("post_rst_addr", ma_o, 32'h600);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences every data-memory access for the MEM stage.
- Arbitrates one single-ported, variable-latency data memory between the pipeline port (P) and a debug/loader port (D).
- Generates byte enables and replicated store data; returns the load word lane-shifted so the MEM stage extension logic only sees the low bytes.
- Drives the pipeline stall while an access is outstanding.

Parameters:
MAX_P_GRANTS, 4, consecutive P grants allowed while d_req is pending before D is forced in.
TIMEOUT, 255, BUSY cycles without mem_ack before the access is aborted with an error.

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-low reset (rst==0 resets)
p_req  in  1  pipeline access request; held until p_stall is low
p_we  in  1  1=store, 0=load
p_addr  in  32  byte address
p_wdata  in  32  store data, low-aligned
p_dm_ctrl  in  3  000 word, 001 halfword, 010 halfword_unsigned, 011 byte, 100 byte_unsigned
p_stall  out  1  freeze pipeline
p_rdata  out  32  load word shifted right by 8*addr[1:0]
p_bias  out  2  addr[1:0] of the completed access
d_req, d_we, d_addr, d_wdata, d_dm_ctrl  in  1/1/32/32/3  debug port, same meaning as the P port
d_done  out  1  one-cycle completion pulse for D
d_rdata  out  32  same format as p_rdata
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  write strobe
mem_addr  out  32  word address: {addr[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  replicated store data
mem_ack  in  1  access complete; mem_rdata valid in the same cycle
mem_rdata  in  32  read word
err  out  1  one-cycle pulse: misaligned access or timeout

Behaviour:
- Reset (async, rst==0):
  - State = IDLE; owner = P.
  - mem_req, mem_we, mem_be, err, d_done = 0; grant counter and timeout counter = 0.
  - p_rdata, d_rdata, mem_addr, mem_wdata, p_bias = 0.
  - mem_req drops immediately, including mid-access. A pending memory transaction is abandoned; the memory must tolerate this.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE arbitration:
  - Grant D if d_req && (!p_req || grant counter == MAX_P_GRANTS); otherwise grant P if p_req.
  - On grant: latch we/addr/wdata/dm_ctrl and owner.
  - Grant counter: increments on each P grant while d_req=1; clears on a D grant or whenever d_req=0.
- Misaligned access (word with addr[1:0]!=0, half with addr[0]=1):
  - No memory access is issued; go IDLE->DONE directly.
  - err=1 in DONE; returned rdata = 0; stores are dropped.
- Aligned access: IDLE->BUSY. In BUSY, mem_req=1 with mem_we/mem_addr/mem_be/mem_wdata stable.
  - On mem_ack: capture mem_rdata>>(8*addr[1:0]) into the owner's rdata register; clear mem_req; ->DONE.
  - If the timeout counter reaches TIMEOUT with no ack: clear mem_req; rdata=0; err=1 in DONE.
- DONE: lasts one cycle, then ->IDLE. p_bias updates for P accesses; d_done=1 if owner==D.
- p_stall = p_req && !(state==DONE && owner==P). It is combinational, so stall falls in the DONE cycle and the pipeline advances on that edge.
- Minimum latency: req seen in IDLE at cycle T, mem_req in T+1, ack in T+1, DONE in T+2. A P access therefore stalls 2 cycles minimum; a misaligned access stalls 1 cycle.
- Byte enables: word 1111; half 0011<<(2*addr[1]); byte 0001<<addr[1:0].
- Store data: word passthrough; half {2{wdata[15:0]}}; byte {4{wdata[7:0]}}.
- Loads drive mem_be per dm_ctrl as well. Unsigned and signed variants share lane logic; the MEM stage performs the extension.
- Undefined dm_ctrl (101-111): treated as word.

Test Plan:
- Aligned P word load at 0x100, memory acks after 3 cycles with 0xDEADBEEF -> mem_be=1111; p_stall high 4 cycles; p_rdata=0xDEADBEEF; p_bias=0.
- P byte store 0xA5 at 0x103 -> mem_addr=0x100, mem_be=1000, mem_wdata=0xA5A5A5A5, mem_we=1. Then byte load at 0x103 with mem_rdata=0xA5000000 -> p_rdata[7:0]=0xA5, p_bias=3.
- P halfword load at 0x101 -> no mem_req; err pulses once; p_rdata=0; p_stall high exactly 1 cycle.
- p_req and d_req both held continuously, ack 1 cycle after each request -> grant order P,P,P,P,D,P,P,P,P,D; d_done pulses once per D access.
- Memory never acks, TIMEOUT=8 -> mem_req high 8 cycles then drops; err=1; state returns to IDLE; next request is served normally.
- rst pulled low while in BUSY -> mem_req, p_rdata and err are 0 before the next clock edge. After release, an IDLE request is accepted normally.
